// File: rtl/shift_seq_pkg.sv
// Shared widths, shift opcodes and sequencer states for the MIX shift sequencer.
package shift_seq_pkg;

    localparam int unsigned FIELD_W = 4;
    localparam int unsigned M_W     = 12;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [FIELD_W-1:0] {
        SH_SLA  = 4'd0,
        SH_SRA  = 4'd1,
        SH_SLAX = 4'd2,
        SH_SRAX = 4'd3,
        SH_SLC  = 4'd4,
        SH_SRC  = 4'd5
    } shift_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

endpackage

// File: rtl/shift_seq_if.sv
// Request/result bundle between the instruction decoder and the shift sequencer.
interface shift_seq_if
    import shift_seq_pkg::*;
#(
    parameter int unsigned BYTE_W     = 6,
    parameter int unsigned WORD_BYTES = 5
);
    localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;

    logic               start;
    logic [FIELD_W-1:0] field;
    logic [M_W-1:0]     m;
    logic [WORD_W-1:0]  ina;
    logic [WORD_W-1:0]  inx;
    logic [WORD_W-1:0]  outa;
    logic [WORD_W-1:0]  outx;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, field, m, ina, inx,
        input  outa, outx, busy, done, err
    );

    modport slave (
        input  start, field, m, ina, inx,
        output outa, outx, busy, done, err
    );

endinterface

// File: rtl/shift_seq_count.sv
// Effective byte count for a shift request: clamped for SLA/SRA/SLAX/SRAX, mod 2W for rotates.
module shift_count
    import shift_seq_pkg::*;
#(
    parameter int unsigned WORD_BYTES = 5
) (
    input  logic [FIELD_W-1:0] field,
    input  logic [M_W-1:0]     m,
    output logic [CNT_W-1:0]   n,
    output logic               err
);
    localparam logic [M_W-1:0] ONE_W = M_W'(WORD_BYTES);
    localparam logic [M_W-1:0] TWO_W = M_W'(2 * WORD_BYTES);

    shift_op_e op;

    always_comb begin
        op  = shift_op_e'(field);
        n   = '0;
        err = 1'b0;
        case (op)
            SH_SLA, SH_SRA:   n = (m > ONE_W) ? CNT_W'(ONE_W) : CNT_W'(m);
            SH_SLAX, SH_SRAX: n = (m > TWO_W) ? CNT_W'(TWO_W) : CNT_W'(m);
            SH_SLC, SH_SRC:   n = CNT_W'(m % TWO_W);
            default:          err = 1'b1;
        endcase
    end

endmodule

// File: rtl/shift_seq.sv
// MIX shift sequencer: captures rA/rX, then moves the 60-bit AX pair one byte per cycle.
module shift_seq
    import shift_seq_pkg::*;
#(
    parameter int unsigned BYTE_W     = 6,
    parameter int unsigned WORD_BYTES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    shift_seq_if.slave bus
);
    localparam int unsigned WORD_W = BYTE_W * WORD_BYTES;
    localparam int unsigned AX_W   = 2 * WORD_W;

    state_e           state;
    shift_op_e        op;
    logic [AX_W-1:0]  ax;
    logic [AX_W-1:0]  ax_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] n;
    logic             cnt_err;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    shift_count #(.WORD_BYTES(WORD_BYTES)) u_count (
        .field (bus.field),
        .m     (bus.m),
        .n     (n),
        .err   (cnt_err)
    );

    // A occupies the upper word of AX; SLA/SRA touch only that half.
    always_comb begin
        ax_next = ax;
        case (op)
            SH_SLA:  ax_next[AX_W-1 -: WORD_W] = {ax[AX_W-BYTE_W-1 -: WORD_W-BYTE_W], {BYTE_W{1'b0}}};
            SH_SRA:  ax_next[AX_W-1 -: WORD_W] = {{BYTE_W{1'b0}}, ax[AX_W-1 -: WORD_W-BYTE_W]};
            SH_SLAX: ax_next = ax << BYTE_W;
            SH_SRAX: ax_next = ax >> BYTE_W;
            SH_SLC:  ax_next = {ax[AX_W-BYTE_W-1:0], ax[AX_W-1 -: BYTE_W]};
            SH_SRC:  ax_next = {ax[BYTE_W-1:0], ax[AX_W-1:BYTE_W]};
            default: ax_next = ax;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            op     <= SH_SLA;
            ax     <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        ax     <= {bus.ina, bus.inx};
                        op     <= shift_op_e'(bus.field);
                        cnt    <= n;
                        busy_q <= 1'b1;
                        err_q  <= cnt_err;
                        if (n != '0 && !cnt_err) begin
                            state <= S_SHIFT;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    ax  <= ax_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.outa = ax[AX_W-1 -: WORD_W];
    assign bus.outx = ax[WORD_W-1:0];
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule
